multicycle_ctrl: RTL

Multi-cycle main control unit for the teaching MIPS-style datapath; successor to the single-cycle 3-bit-opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, stalls on a memory ready handshake, and flags illegal opcodes. Opcode width is parametrised. Control outputs drive the PC, IR, register file, ALU muxes and unified memory.

---
 rtl/mcctrl_pkg.sv | 60 ++++++
 rtl/mcctrl_decode.sv | 79 +++++++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mcctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-style control unit: states, opcodes,
// mux/ALU select codes and the bundled control word.
package mcctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC,
        ST_RWB,
        ST_BRANCH,
        ST_JUMP,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_TRAP
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_LW    = 3'd1;
    localparam logic [2:0] OP_SW    = 3'd2;
    localparam logic [2:0] OP_BEQ   = 3'd3;
    localparam logic [2:0] OP_J     = 3'd4;
    localparam logic [2:0] OP_ADDI  = 3'd5;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       busy;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/mcctrl_decode.sv
// Combinational control-word decode from the current state; the fetch strobes
// into PC and IR only fire on the cycle the memory returns data.
module mcctrl_decode
    import mcctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl      = '0;
        ctrl.busy = (state != ST_IDLE);
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
            end
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: state register, next-state logic and, with
// MCCTRL_PERF_EN defined, busy-cycle and retired-instruction counters.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read, PC+4 (waits on mem_ready)
// DECODE | opcode dispatch, branch target precompute
// MEMADR | load/store address compute
// MEMRD  | data read (waits on mem_ready)
// MEMWB  | load write-back
// MEMWR  | data write (waits on mem_ready)
// EXEC   | R-type ALU operation
// RWB    | R-type write-back
// BRANCH | BEQ compare and conditional PC update
// JUMP   | PC <- jump target
// ADDIEX | ADDI ALU operation
// ADDIWB | ADDI write-back
// TRAP   | illegal opcode, parked until run drops
module multicycle_ctrl
    import mcctrl_pkg::*;
#(
    parameter int OPC_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             busy,
    output logic             trap
`ifdef MCCTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    state_t state_q, state_d;
    logic   is_load_q, is_load_d;
    logic   eoi;
    logic   opc_legal;
    ctrl_t  ctrl;

    // The datapath ANDs zero with pc_write_cond; the FSM itself never needs it.
    logic unused_zero;
    assign unused_zero = zero;

    assign opc_legal = ((opcode >> 3) == '0);

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        eoi       = 1'b0;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!opc_legal) begin
                    state_d = ST_TRAP;
                end else begin
                    case (opcode[2:0])
                        OP_LW:    begin state_d = ST_MEMADR; is_load_d = 1'b1; end
                        OP_SW:    begin state_d = ST_MEMADR; is_load_d = 1'b0; end
                        OP_RTYPE: state_d = ST_EXEC;
                        OP_BEQ:   state_d = ST_BRANCH;
                        OP_J:     state_d = ST_JUMP;
                        OP_ADDI:  state_d = ST_ADDIEX;
                        default:  state_d = ST_TRAP;
                    endcase
                end
            end
            ST_MEMADR: state_d = is_load_q ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) begin
                eoi     = 1'b1;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_EXEC:   state_d = ST_RWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: begin
                eoi     = 1'b1;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP:   if (!run) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

    mcctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign i_or_d        = ctrl.i_or_d;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign busy          = ctrl.busy;
    assign trap          = ctrl.trap;

`ifdef MCCTRL_PERF_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + CNT_W'(ctrl.busy);
        ret_cnt_d = ret_cnt_q + CNT_W'(eoi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
    logic unused_eoi;
    assign unused_eoi = eoi;
`endif

endmodule
